// File: rtl/apb_gpio_irq.sv
// rtl/apb_gpio_irq.sv - APB3 GPIO with wait states, 2-flop input sync and edge IRQs
// Interrupt logic is built only when GPIO_IRQ_EN is defined; otherwise irq_o is tied 0.
module apb_gpio_irq #(
  parameter int GPIO_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic [3:0]        paddr_i,
  input  logic              pwrite_i,
  input  logic [GPIO_W-1:0] pwdata_i,
  output logic [GPIO_W-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq_o
);

  localparam logic [1:0] WS = 2'(WAIT_STATES);

  logic [1:0]        wcnt_q, wcnt_d;
  logic [GPIO_W-1:0] dout_q, dout_d, dir_q, dir_d;
  logic [GPIO_W-1:0] sync0_q, sync1_q;
  logic [GPIO_W-1:0] ien_rd, itype_rd, istat_rd, rdata;
  logic              access, addr_err, wr_en;

  assign access    = psel_i & penable_i;
  assign addr_err  = paddr_i[3];
  // Gated by reset so an access held across an asserted reset never looks complete.
  assign pready_o  = preset_n & access & (wcnt_q == WS);
  assign pslverr_o = pready_o & addr_err;
  assign wr_en     = pready_o & pwrite_i & ~addr_err;
  assign prdata_o  = (pready_o & ~addr_err) ? rdata : '0;
  assign gpio_o    = dout_q;
  assign gpio_oe   = dir_q;

  always_comb begin
    wcnt_d = wcnt_q;
    if (!access)          wcnt_d = 2'd0;
    else if (wcnt_q != WS) wcnt_d = wcnt_q + 2'd1;
  end

  always_comb begin
    dout_d = dout_q;
    dir_d  = dir_q;
    if (wr_en) begin
      case (paddr_i[2:0])
        3'd0:    dout_d = pwdata_i;
        3'd1:    dir_d  = pwdata_i;
        3'd6:    dout_d = dout_q | pwdata_i;
        3'd7:    dout_d = dout_q & ~pwdata_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (paddr_i[2:0])
      3'd0:    rdata = dout_q;
      3'd1:    rdata = dir_q;
      3'd2:    rdata = sync1_q;
      3'd3:    rdata = ien_rd;
      3'd4:    rdata = itype_rd;
      3'd5:    rdata = istat_rd;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wcnt_q  <= 2'd0;
      dout_q  <= '0;
      dir_q   <= '0;
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      dout_q  <= dout_d;
      dir_q   <= dir_d;
      sync0_q <= gpio_i;
      sync1_q <= sync0_q;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [GPIO_W-1:0] prev_q, ien_q, ien_d, itype_q, itype_d, istat_q, istat_d;
  logic [GPIO_W-1:0] evt, w1c;
  logic              irq_q;

  assign evt      = ien_q & ((itype_q & sync1_q & ~prev_q) | (~itype_q & ~sync1_q & prev_q));
  assign w1c      = (wr_en && paddr_i[2:0] == 3'd5) ? pwdata_i : '0;
  assign ien_rd   = ien_q;
  assign itype_rd = itype_q;
  assign istat_rd = istat_q;
  assign irq_o    = irq_q;

  always_comb begin
    ien_d   = ien_q;
    itype_d = itype_q;
    if (wr_en && paddr_i[2:0] == 3'd3) ien_d   = pwdata_i;
    if (wr_en && paddr_i[2:0] == 3'd4) itype_d = pwdata_i;
    // New events are OR-ed after the clear so a coincident edge keeps its bit set.
    istat_d = (istat_q & ~w1c) | evt;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      prev_q  <= '0;
      ien_q   <= '0;
      itype_q <= '0;
      istat_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      prev_q  <= sync1_q;
      ien_q   <= ien_d;
      itype_q <= itype_d;
      istat_q <= istat_d;
      irq_q   <= |istat_q;
    end
  end
`else
  assign ien_rd   = '0;
  assign itype_rd = '0;
  assign istat_rd = '0;
  assign irq_o    = 1'b0;
`endif

endmodule
